// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: a direct-mapped tagged table with 2-bit
// saturating counters, trained at EX, plus mispredict detection and perf counters.
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] fetchPc,
  output logic        predTaken,
  output logic [31:0] predTarget,
  output logic [1:0]  predPcSource,
  input  logic        exValid,
  input  logic        exBranch,
  input  logic        exJump,
  input  logic        exJalr,
  input  logic [31:0] exPc,
  input  logic [31:0] exTarget,
  input  logic [1:0]  exPcSource,
  input  logic        exPredTaken,
  input  logic [31:0] exPredTarget,
  output logic        mispredict,
  output logic [31:0] recoveryPc,
  output logic [15:0] ctrlCount,
  output logic [15:0] mispredCount
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                  validArr  [ENTRIES];
  logic [TAG_BITS-1:0]   tagArr    [ENTRIES];
  logic [31:0]           targetArr [ENTRIES];
  logic [1:0]            ctrArr    [ENTRIES];
  logic                  uncondArr [ENTRIES];

  logic [INDEX_BITS-1:0] fetchIdx;
  logic [TAG_BITS-1:0]   fetchTag;
  logic [INDEX_BITS-1:0] exIdx;
  logic [TAG_BITS-1:0]   exTag;
  logic                  fetchHit;
  logic                  exHit;
  logic                  actualTaken;
  logic                  trainEn;
  logic                  unusedPcBits;

  assign fetchIdx     = fetchPc[INDEX_BITS+1:2];
  assign fetchTag     = fetchPc[31:INDEX_BITS+2];
  assign exIdx        = exPc[INDEX_BITS+1:2];
  assign exTag        = exPc[31:INDEX_BITS+2];
  assign unusedPcBits = ^{fetchPc[1:0], exPc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is never seen here.
  always_comb begin
    fetchHit     = validArr[fetchIdx] && (tagArr[fetchIdx] == fetchTag);
    predTaken    = rstN && fetchHit && (ctrArr[fetchIdx][1] || uncondArr[fetchIdx]);
    predTarget   = predTaken ? targetArr[fetchIdx] : 32'd0;
    predPcSource = {1'b0, predTaken};
  end

  // Resolution is combinational so the flush can be taken on the following edge.
  always_comb begin
    actualTaken = (exPcSource != 2'b00);
    mispredict  = rstN && exValid &&
                  ((actualTaken != exPredTaken) || (actualTaken && (exTarget != exPredTarget)));
    recoveryPc  = 32'd0;
    if (mispredict) begin
      recoveryPc = actualTaken ? exTarget : (exPc + 32'd4);
    end
    exHit   = validArr[exIdx] && (tagArr[exIdx] == exTag);
    trainEn = exValid && (exBranch || exJump) && !exJalr;
  end

  // jalr never trains: its target comes from a register, so the table cannot help.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validArr[i]  <= 1'b0;
        tagArr[i]    <= '0;
        targetArr[i] <= 32'd0;
        ctrArr[i]    <= 2'b01;
        uncondArr[i] <= 1'b0;
      end
    end else if (trainEn) begin
      if (exHit) begin
        if (actualTaken) begin
          targetArr[exIdx] <= exTarget;
          if (ctrArr[exIdx] != 2'b11) begin
            ctrArr[exIdx] <= ctrArr[exIdx] + 2'd1;
          end
        end else if (ctrArr[exIdx] != 2'b00) begin
          ctrArr[exIdx] <= ctrArr[exIdx] - 2'd1;
        end
      end else if (actualTaken) begin
        validArr[exIdx]  <= 1'b1;
        tagArr[exIdx]    <= exTag;
        targetArr[exIdx] <= exTarget;
        ctrArr[exIdx]    <= 2'b10;
        uncondArr[exIdx] <= exJump;
      end
    end
  end

  // Saturating performance counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ctrlCount    <= 16'd0;
      mispredCount <= 16'd0;
    end else begin
      if (exValid && (ctrlCount != 16'hFFFF)) begin
        ctrlCount <= ctrlCount + 16'd1;
      end
      if (mispredict && (mispredCount != 16'hFFFF)) begin
        mispredCount <= mispredCount + 16'd1;
      end
    end
  end

endmodule
